mc_mem_responder: RTL and testbench

Memory-side responder for the multi-cycle RISC-V core's unified memory port (Adr/MemWrite/WriteData out, ReadData in).
Decodes each access into one of three regions: a word-addressed unified instruction/data RAM, a small MMIO register block (LED register, prescaled 32-bit timer with compare/match flag), or unmapped space.
Sits beside the core at SoC top level; one access per clock; no wait states.

---
 rtl/mc_mem_responder.sv | 145 ++++++++++++++
 tb/tb_mc_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_mem_responder.sv
// Unified RAM + MMIO (LED, prescaled timer with compare) responder for the multi-cycle core.
// Build option TIMER_IRQ_EN adds the irq output and a writable STATUS.IRQ_EN bit.
module mc_mem_responder #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Adr,
  input  logic             MemWrite,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
`ifdef TIMER_IRQ_EN
  output logic             irq,
`endif
  output logic [LED_W-1:0] leds
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [32:0] RAM_LIMIT = 33'(MEM_WORDS) << 2;
  localparam logic [5:0]  OFF_LED    = 6'd0;
  localparam logic [5:0]  OFF_TCOUNT = 6'd1;
  localparam logic [5:0]  OFF_TCMP   = 6'd2;
  localparam logic [5:0]  OFF_STATUS = 6'd3;
  localparam logic [5:0]  OFF_PRESC  = 6'd4;

  logic [31:0]      mem [MEM_WORDS];
  logic [LED_W-1:0] led_q;
  logic [31:0]      tcount_q;
  logic [31:0]      tcmp_q;
  logic [15:0]      presc_q;
  logic [15:0]      pc_q;
  logic             match_q;
  logic             err_q;
  logic             irq_en_rd;

  logic             is_ram;
  logic             is_mmio;
  logic             reg_hit;
  logic [5:0]       off;
  logic [AW-1:0]    ram_idx;
  logic             wr_led, wr_tcount, wr_tcmp, wr_status, wr_presc;
  logic             tick;
  logic [31:0]      tcount_inc;
  logic             match_set;
  logic             err_set;
  logic             unused_adr;

  // Byte lanes are not supported, so the two low address bits carry no meaning.
  assign unused_adr = ^Adr[1:0];

  assign is_ram  = ({1'b0, Adr} < RAM_LIMIT);
  assign is_mmio = !is_ram && (Adr[31:8] == MMIO_BASE[31:8]);
  assign off     = Adr[7:2];
  assign ram_idx = Adr[AW+1:2];
  assign reg_hit = is_mmio && (off <= OFF_PRESC);

  assign wr_led    = MemWrite && is_mmio && (off == OFF_LED);
  assign wr_tcount = MemWrite && is_mmio && (off == OFF_TCOUNT);
  assign wr_tcmp   = MemWrite && is_mmio && (off == OFF_TCMP);
  assign wr_status = MemWrite && is_mmio && (off == OFF_STATUS);
  assign wr_presc  = MemWrite && is_mmio && (off == OFF_PRESC);

  assign tick       = (pc_q == presc_q);
  assign tcount_inc = tcount_q + 32'd1;
  // A CPU load of TCOUNT overrides the tick and suppresses the compare.
  assign match_set  = tick && !wr_tcount && (tcount_inc == tcmp_q);
  assign err_set    = MemWrite && !is_ram && !reg_hit;

  always_comb begin
    ReadData = '0;
    if (is_ram) begin
      ReadData = mem[ram_idx];
    end else if (is_mmio) begin
      case (off)
        OFF_LED:    ReadData = 32'(led_q);
        OFF_TCOUNT: ReadData = tcount_q;
        OFF_TCMP:   ReadData = tcmp_q;
        OFF_STATUS: ReadData = {29'd0, irq_en_rd, err_q, match_q};
        OFF_PRESC:  ReadData = {16'd0, presc_q};
        default:    ReadData = '0;
      endcase
    end
  end

  // RAM keeps its contents through reset; only the write is gated.
  always_ff @(posedge clk) begin
    if (reset && MemWrite && is_ram) begin
      mem[ram_idx] <= WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q    <= '0;
      tcount_q <= '0;
      tcmp_q   <= '0;
      presc_q  <= '0;
      pc_q     <= '0;
      match_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (wr_presc || tick) begin
        pc_q <= '0;
      end else begin
        pc_q <= pc_q + 16'd1;
      end

      if (wr_tcount) begin
        tcount_q <= WriteData;
      end else if (tick) begin
        tcount_q <= tcount_inc;
      end

      if (wr_led)   led_q   <= WriteData[LED_W-1:0];
      if (wr_tcmp)  tcmp_q  <= WriteData;
      if (wr_presc) presc_q <= WriteData[15:0];

      // Set beats a same-cycle W1C for both sticky flags.
      match_q <= match_set || (match_q && !(wr_status && WriteData[0]));
      err_q   <= err_set   || (err_q   && !(wr_status && WriteData[1]));
    end
  end

`ifdef TIMER_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      irq_en_q <= 1'b0;
    end else if (wr_status) begin
      irq_en_q <= WriteData[2];
    end
  end

  assign irq_en_rd = irq_en_q;
  assign irq       = match_q && irq_en_q;
`else
  assign irq_en_rd = 1'b0;
`endif

  assign leds = led_q;

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: directed scenarios plus random traffic against a behavioural model.
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Adr;
  logic        MemWrite;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  leds;
`ifdef TIMER_IRQ_EN
  logic        irq;
`endif

  mc_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .Adr       (Adr),
    .MemWrite  (MemWrite),
    .WriteData (WriteData),
    .ReadData  (ReadData),
`ifdef TIMER_IRQ_EN
    .irq       (irq),
`endif
    .leds      (leds)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state
  logic [31:0] m_ram [256];
  bit          m_valid [256];
  logic [7:0]  m_led    = '0;
  logic [31:0] m_tcount = '0;
  logic [31:0] m_tcmp   = '0;
  logic [15:0] m_presc  = '0;
  int          m_pc     = 0;
  bit          m_match  = 0;
  bit          m_err    = 0;
  bit          m_irqen  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pre(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (a < 32'd1024) return m_ram[a[9:2]];
    if (a[31:8] == 24'h00_0010) begin
      case (int'(a[7:2]))
        0: return {24'd0, m_led};
        1: return m_tcount;
        2: return m_tcmp;
        3: return {29'd0, m_irqen, m_err, m_match};
        4: return {16'd0, m_presc};
        default: return 32'd0;
      endcase
    end
    return 32'd0;
  endfunction

  task automatic mstep(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rst);
    bit          ram_hit, tick, loaded, set_m, set_e;
    int          reg_no;
    logic [31:0] new_tc;
    if (!rst) begin
      m_led = 0; m_tcount = 0; m_tcmp = 0; m_presc = 0; m_pc = 0;
      m_match = 0; m_err = 0; m_irqen = 0;
      return;
    end
    ram_hit = (a < 32'd1024);
    reg_no  = (!ram_hit && a[31:8] == 24'h00_0010) ? int'(a[7:2]) : -1;
    tick    = (m_pc == int'(m_presc));
    loaded  = w && reg_no == 1;
    new_tc  = loaded ? d : (tick ? m_tcount + 32'd1 : m_tcount);
    set_m   = tick && !loaded && (new_tc == m_tcmp);
    set_e   = w && !ram_hit && !(reg_no >= 0 && reg_no <= 4);
    if (w && ram_hit) begin
      m_ram[a[9:2]]   = d;
      m_valid[a[9:2]] = 1;
    end
    m_pc = ((w && reg_no == 4) || tick) ? 0 : m_pc + 1;
    if (w && reg_no == 0) m_led = d[7:0];
    if (w && reg_no == 2) m_tcmp = d;
    if (w && reg_no == 4) m_presc = d[15:0];
    m_tcount = new_tc;
    if (w && reg_no == 3) begin
      if (d[0]) m_match = 0;
      if (d[1]) m_err = 0;
`ifdef TIMER_IRQ_EN
      m_irqen = d[2];
`endif
    end
    if (set_m) m_match = 1;
    if (set_e) m_err = 1;
  endtask

  // One bus cycle: drive on negedge, check combinational read and outputs, step model on posedge.
  task automatic cyc(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rst,
                     output logic [31:0] obs);
    @(negedge clk);
    Adr = a; MemWrite = w; WriteData = d; reset = rst;
    #1;
    obs = ReadData;
    if (!(a < 32'd1024) || m_valid[a[9:2]]) chk("rdata", ReadData, mread(a));
    chk("leds", {24'd0, leds}, {24'd0, m_led});
`ifdef TIMER_IRQ_EN
    chk("irq", {31'd0, irq}, {31'd0, m_match & m_irqen});
`endif
    @(posedge clk);
    mstep(a, w, d, rst);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] o;
    cyc(a, 1'b1, d, 1'b1, o);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] o);
    cyc(a, 1'b0, 32'd0, 1'b1, o);
  endtask

  logic [31:0] obs;
  int          lat;

  initial begin
    reset = 1'b0; Adr = '0; MemWrite = 1'b0; WriteData = '0;
    repeat (3) @(posedge clk);
    mstep(32'd0, 1'b0, 32'd0, 1'b0);

    // reset state
    rd(32'h1004, obs); chk("rst_tcount", obs, 32'd0);
    rd(32'h1004, obs); chk("tcount_run", obs, 32'd1);
    rd(32'h100C, obs); chk("rst_status", obs, 32'd0);
    rd(32'h1008, obs); chk("rst_tcmp", obs, 32'd0);
    rd(32'h1010, obs); chk("rst_presc", obs, 32'd0);
    rd(32'h1000, obs); chk("rst_led", obs, 32'd0);

    for (int i = 0; i < 256; i++) wr(32'(i) << 2, pre(i));

    // RAM
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, obs); chk("ram_rd10", obs, 32'hDEAD_BEEF);
    rd(32'h13, obs); chk("ram_rd13", obs, 32'hDEAD_BEEF);
    rd(32'h14, obs); chk("ram_rd14", obs, pre(5));

    // timer: PRESC write is cycle 0, TCOUNT reload lands on the tick at cycle 4
    wr(32'h1010, 32'd3);
    wr(32'h1008, 32'd5);
    wr(32'h100C, 32'd7);
    rd(32'h1004, obs);
    wr(32'h1004, 32'd0);
    lat = -1;
    for (int k = 5; k < 60 && lat < 0; k++) begin
      rd(32'h100C, obs);
      if (obs[0]) lat = k - 1;
    end
    chk("match_latency", 32'(lat), 32'd24);
`ifdef TIMER_IRQ_EN
    #1 chk("irq_rise", {31'd0, irq}, 32'd1);
`endif
    rd(32'h1004, obs); chk("tcount_at_match", obs, 32'd5);

    // W1C against a same-cycle match
    wr(32'h1010, 32'd0);
    wr(32'h1008, 32'd12);
    wr(32'h100C, 32'd7);
    wr(32'h1004, 32'd10);
    rd(32'h100C, obs); chk("match_clear", {31'd0, obs[0]}, 32'd0);
    cyc(32'h100C, 1'b1, 32'd7, 1'b1, obs);
    rd(32'h100C, obs); chk("w1c_set_wins", {31'd0, obs[0]}, 32'd1);
    wr(32'h100C, 32'd1);
    rd(32'h100C, obs); chk("w1c_clear", {31'd0, obs[0]}, 32'd0);

    // wrap and collision
    wr(32'h1004, 32'hFFFF_FFFF);
    rd(32'h1004, obs); chk("wrap_pre", obs, 32'hFFFF_FFFF);
    rd(32'h1004, obs); chk("wrap_zero", obs, 32'd0);
    wr(32'h1004, 32'd100);
    rd(32'h1004, obs); chk("collide_load", obs, 32'd100);
    rd(32'h1004, obs); chk("collide_next", obs, 32'd101);

    // errors
    wr(32'h2000, 32'h1234_5678);
    rd(32'h2000, obs); chk("unmap_rd", obs, 32'd0);
    rd(32'h100C, obs); chk("err_unmap", {31'd0, obs[1]}, 32'd1);
    wr(32'h100C, 32'd2);
    rd(32'h100C, obs); chk("err_w1c", {31'd0, obs[1]}, 32'd0);
    wr(32'h1020, 32'hFFFF_FFFF);
    rd(32'h1020, obs); chk("badoff_rd", obs, 32'd0);
    rd(32'h100C, obs); chk("err_badoff", {31'd0, obs[1]}, 32'd1);
    rd(32'h10, obs);   chk("err_ram_kept", obs, 32'hDEAD_BEEF);
    rd(32'h1008, obs); chk("err_tcmp_kept", obs, 32'd12);
    rd(32'h1000, obs); chk("err_led_kept", obs, 32'd0);
    wr(32'h100C, 32'd2);

    // reset mid-count
    wr(32'h1010, 32'd3);
    wr(32'h1000, 32'hFFFF_FFA5);
    rd(32'h1000, obs); chk("led_rd", obs, 32'h0000_00A5);
    chk("leds_a5", {24'd0, leds}, 32'h0000_00A5);
    for (int i = 0; i < 5; i++) rd(32'h1004, obs);
    cyc(32'h10, 1'b1, 32'h3C3C_3C3C, 1'b0, obs);
    chk("rst_ram_read", obs, 32'hDEAD_BEEF);
    #1 chk("rst_leds", {24'd0, leds}, 32'd0);
    rd(32'h1004, obs); chk("rst_tcount2", obs, 32'd0);
    rd(32'h100C, obs); chk("rst_status2", obs, 32'd0);
    rd(32'h10, obs);   chk("rst_ram_kept", obs, 32'hDEAD_BEEF);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic        w, r;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
        4, 5, 6, 7: a = 32'h1000 | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
        8:          a = 32'h8000_0000 | $urandom;
        default:    a = 32'h1000 | $urandom_range(0, 255);
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 1) ? 32'($urandom_range(0, 7)) : $urandom;
      r = ($urandom_range(0, 99) != 0);
      cyc(a, w, d, r, obs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
